// File: rtl/instruction_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : instruction_loader                                           |
// | Description : Boot-time loader for the MiniAlu instruction RAM. Parses a   |
// |               big-endian 16-bit word count followed by 4-byte words, then  |
// |               writes 28-bit instructions to sequential addresses. The core |
// |               is held in reset until the image is complete.                |
// |               Optional macro LOADER_CHECKSUM_EN adds a trailing XOR        |
// |               checksum byte that must match before the core is released.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module instruction_loader #(
  parameter int MAX_WORDS  = 256,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [7:0]            iByte,
  input  logic                  iByteValid,
  output logic                  oByteReady,
  output logic                  oWriteEnable,
  output logic [ADDR_WIDTH-1:0] oWriteAddress,
  output logic [27:0]           oInstruction,
  output logic                  oCpuReset,
  output logic                  oDone,
  output logic                  oError
);

  localparam logic [16:0] c_MAX_WORDS = 17'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_LO = 3'd1,
    S_DATA   = 3'd2,
    S_FLUSH  = 3'd3,
    S_CHECK  = 3'd4,
    S_DONE   = 3'd5,
    S_ERROR  = 3'd6
  } state_t;

  state_t                r_state;
  logic [7:0]            r_len_hi;
  logic [15:0]           r_remaining;
  logic [1:0]            r_byte_cnt;
  logic [3:0]            r_opcode;
  logic [7:0]            r_b1;
  logic [7:0]            r_b2;
  logic                  r_ready;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [27:0]           r_instr;
  logic                  r_cpu_reset;
  logic                  r_done;
  logic                  r_error;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]            r_xor;
`endif

  logic        w_accept;
  logic [15:0] w_len;

  assign w_accept = iByteValid & r_ready;
  assign w_len    = {r_len_hi, iByte};

  // Loader FSM: parses the stream, assembles words and drives all registered outputs
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state     <= S_IDLE;
      r_len_hi    <= 8'd0;
      r_remaining <= 16'd0;
      r_byte_cnt  <= 2'd0;
      r_opcode    <= 4'd0;
      r_b1        <= 8'd0;
      r_b2        <= 8'd0;
      r_ready     <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_instr     <= 28'd0;
      r_cpu_reset <= 1'b1;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      r_xor       <= 8'd0;
`endif
    end else begin
      // The strobe is a single cycle; the address advances as it drops so
      // oWriteAddress stays stable for the whole write cycle.
      r_we <= 1'b0;
      if (r_we) begin
        r_addr <= r_addr + 1'b1;
      end
      // Core release lags DONE by one cycle so the last write has fully retired.
      r_done      <= (r_state == S_DONE);
      r_cpu_reset <= (r_state != S_DONE);

      case (r_state)
        S_IDLE: begin
          r_ready <= 1'b1;
          if (w_accept) begin
            r_len_hi <= iByte;
            r_state  <= S_LEN_LO;
          end
        end

        S_LEN_LO: begin
          if (w_accept) begin
            if (w_len == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
              r_state <= S_CHECK;
`else
              r_state <= S_DONE;
              r_ready <= 1'b0;
`endif
            end else if ({1'b0, w_len} > c_MAX_WORDS) begin
              r_state <= S_ERROR;
              r_ready <= 1'b0;
              r_error <= 1'b1;
            end else begin
              r_state     <= S_DATA;
              r_remaining <= w_len;
              r_byte_cnt  <= 2'd0;
            end
          end
        end

        S_DATA: begin
          if (w_accept) begin
`ifdef LOADER_CHECKSUM_EN
            r_xor <= r_xor ^ iByte;
`endif
            case (r_byte_cnt)
              2'd0: begin
                // Upper nibble of B0 is reserved; a nonzero value aborts the load.
                if (iByte[7:4] != 4'd0) begin
                  r_state <= S_ERROR;
                  r_ready <= 1'b0;
                  r_error <= 1'b1;
                end else begin
                  r_opcode   <= iByte[3:0];
                  r_byte_cnt <= 2'd1;
                end
              end
              2'd1: begin
                r_b1       <= iByte;
                r_byte_cnt <= 2'd2;
              end
              2'd2: begin
                r_b2       <= iByte;
                r_byte_cnt <= 2'd3;
              end
              default: begin
                r_we        <= 1'b1;
                r_instr     <= {r_opcode, r_b1, r_b2, iByte};
                r_byte_cnt  <= 2'd0;
                r_remaining <= r_remaining - 16'd1;
                if (r_remaining == 16'd1) begin
                  r_state <= S_FLUSH;
                  r_ready <= 1'b0;
                end
              end
            endcase
          end
        end

        S_FLUSH: begin
`ifdef LOADER_CHECKSUM_EN
          r_state <= S_CHECK;
          r_ready <= 1'b1;
`else
          r_state <= S_DONE;
`endif
        end

`ifdef LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (w_accept) begin
            r_ready <= 1'b0;
            if (iByte == r_xor) begin
              r_state <= S_DONE;
            end else begin
              r_state <= S_ERROR;
              r_error <= 1'b1;
            end
          end
        end
`endif

        default: begin
          // DONE and ERROR are terminal; only Reset leaves them.
        end
      endcase
    end
  end

  assign oByteReady    = r_ready;
  assign oWriteEnable  = r_we;
  assign oWriteAddress = r_addr;
  assign oInstruction  = r_instr;
  assign oCpuReset     = r_cpu_reset;
  assign oDone         = r_done;
  assign oError        = r_error;

endmodule
`default_nettype wire

// File: tb/tb_instruction_loader.sv
`default_nettype none
// Directed testbench for instruction_loader.
module tb_instruction_loader;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [7:0]  iByte = 8'd0;
  logic        iByteValid = 1'b0;
  logic        oByteReady;
  logic        oWriteEnable;
  logic [15:0] oWriteAddress;
  logic [27:0] oInstruction;
  logic        oCpuReset;
  logic        oDone;
  logic        oError;

  int n_checks = 0;
  int n_fail   = 0;

  int          wcount = 0;
  logic [27:0] wr_data [0:7];
  logic [15:0] wr_addr [0:7];

  instruction_loader #(.MAX_WORDS(256), .ADDR_WIDTH(16)) dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .iByte         (iByte),
    .iByteValid    (iByteValid),
    .oByteReady    (oByteReady),
    .oWriteEnable  (oWriteEnable),
    .oWriteAddress (oWriteAddress),
    .oInstruction  (oInstruction),
    .oCpuReset     (oCpuReset),
    .oDone         (oDone),
    .oError        (oError)
  );

  always #5 Clock = ~Clock;

  // Capture every write strobe seen away from the active edge.
  always @(negedge Clock) begin
    if (oWriteEnable === 1'b1) begin
      if (wcount < 8) begin
        wr_data[wcount] = oInstruction;
        wr_addr[wcount] = oWriteAddress;
      end
      wcount = wcount + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    iByteValid = 1'b0;
    Reset = 1'b1;
    @(negedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
    wcount = 0;
  endtask

  // Present one byte from a negedge until it is accepted, then optionally idle.
  task automatic send(input logic [7:0] b, input int gap);
    int t = 0;
    iByte = b;
    iByteValid = 1'b1;
    while (oByteReady !== 1'b1 && t < 20) begin
      @(negedge Clock);
      t++;
    end
    if (t >= 20) chk("ready_timeout", {31'd0, oByteReady}, 32'd1);
    @(posedge Clock);
    @(negedge Clock);
    if (gap > 0) begin
      iByteValid = 1'b0;
      repeat (gap) @(negedge Clock);
    end
  endtask

  task automatic send_two_word(input int gap);
    logic [7:0] s [0:9];
    s = '{8'h00, 8'h02, 8'h07, 8'h01, 8'h02, 8'h03, 8'h02, 8'h04, 8'h05, 8'h06};
    for (int i = 0; i < 10; i++) send(s[i], gap);
    iByteValid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values while Reset is held
    repeat (2) @(negedge Clock);
    chk("rst_ready",   {31'd0, oByteReady},   32'd0);
    chk("rst_we",      {31'd0, oWriteEnable}, 32'd0);
    chk("rst_addr",    {16'd0, oWriteAddress}, 32'd0);
    chk("rst_instr",   {4'd0, oInstruction},  32'd0);
    chk("rst_cpurst",  {31'd0, oCpuReset},    32'd1);
    chk("rst_done",    {31'd0, oDone},        32'd0);
    chk("rst_error",   {31'd0, oError},       32'd0);
    Reset = 1'b0;
    wcount = 0;
    @(negedge Clock);
    chk("idle_ready",  {31'd0, oByteReady},   32'd1);

    // Two words, back to back
    send_two_word(0);
    chk("t1_we_last",  {31'd0, oWriteEnable}, 32'd1);
    chk("t1_addr_last",{16'd0, oWriteAddress}, 32'd1);
    chk("t1_ins_last", {4'd0, oInstruction},  32'h2040506);
    chk("t1_ready_fl", {31'd0, oByteReady},   32'd0);
    chk("t1_cpurst_k", {31'd0, oCpuReset},    32'd1);
    @(negedge Clock);
    chk("t1_we_off",   {31'd0, oWriteEnable}, 32'd0);
    chk("t1_addr_inc", {16'd0, oWriteAddress}, 32'd2);
    chk("t1_done_k1",  {31'd0, oDone},        32'd0);
    chk("t1_cpurst_k1",{31'd0, oCpuReset},    32'd1);
    @(negedge Clock);
    chk("t1_done",     {31'd0, oDone},        32'd1);
    chk("t1_cpurst",   {31'd0, oCpuReset},    32'd0);
    chk("t1_error",    {31'd0, oError},       32'd0);
    chk("t1_wcount",   wcount,                32'd2);
    chk("t1_a0",       {16'd0, wr_addr[0]},   32'd0);
    chk("t1_d0",       {4'd0, wr_data[0]},    32'h7010203);
    chk("t1_a1",       {16'd0, wr_addr[1]},   32'd1);
    chk("t1_d1",       {4'd0, wr_data[1]},    32'h2040506);

    // Same stream with 3 idle cycles between bytes
    do_reset();
    send_two_word(3);
    repeat (3) @(negedge Clock);
    chk("t2_wcount",   wcount,                32'd2);
    chk("t2_a0",       {16'd0, wr_addr[0]},   32'd0);
    chk("t2_d0",       {4'd0, wr_data[0]},    32'h7010203);
    chk("t2_a1",       {16'd0, wr_addr[1]},   32'd1);
    chk("t2_d1",       {4'd0, wr_data[1]},    32'h2040506);
    chk("t2_done",     {31'd0, oDone},        32'd1);
    chk("t2_cpurst",   {31'd0, oCpuReset},    32'd0);

    // Zero-length image
    do_reset();
    send(8'h00, 0);
    send(8'h00, 0);
`ifdef LOADER_CHECKSUM_EN
    send(8'h00, 0);
`endif
    iByteValid = 1'b0;
    chk("t3_ready",    {31'd0, oByteReady},   32'd0);
    repeat (2) @(negedge Clock);
    chk("t3_done",     {31'd0, oDone},        32'd1);
    chk("t3_cpurst",   {31'd0, oCpuReset},    32'd0);
    chk("t3_wcount",   wcount,                32'd0);

    // Oversized header: 257 words
    do_reset();
    send(8'h01, 0);
    send(8'h01, 0);
    iByteValid = 1'b0;
    chk("t4_error",    {31'd0, oError},       32'd1);
    chk("t4_ready",    {31'd0, oByteReady},   32'd0);
    repeat (3) @(negedge Clock);
    chk("t4_cpurst",   {31'd0, oCpuReset},    32'd1);
    chk("t4_done",     {31'd0, oDone},        32'd0);

    // Boundary: exactly MAX_WORDS is accepted
    do_reset();
    send(8'h01, 0);
    send(8'h00, 0);
    iByteValid = 1'b0;
    chk("t4b_error",   {31'd0, oError},       32'd0);
    chk("t4b_ready",   {31'd0, oByteReady},   32'd1);

    // Bad B0 upper nibble
    do_reset();
    send(8'h00, 0);
    send(8'h01, 0);
    send(8'h17, 0);
    iByte = 8'h01;
    chk("t5_error",    {31'd0, oError},       32'd1);
    chk("t5_ready",    {31'd0, oByteReady},   32'd0);
    repeat (6) @(negedge Clock);
    iByteValid = 1'b0;
    chk("t5_wcount",   wcount,                32'd0);
    chk("t5_cpurst",   {31'd0, oCpuReset},    32'd1);

    // Asynchronous reset mid-load, then reload
    do_reset();
    send(8'h00, 0);
    send(8'h02, 0);
    send(8'h07, 0);
    send(8'h01, 0);
    iByteValid = 1'b0;
    #2 Reset = 1'b1;
    #1;
    chk("t6_ready",    {31'd0, oByteReady},   32'd0);
    chk("t6_cpurst",   {31'd0, oCpuReset},    32'd1);
    chk("t6_addr",     {16'd0, oWriteAddress}, 32'd0);
    @(negedge Clock);
    Reset = 1'b0;
    wcount = 0;
    send(8'h00, 0);
    send(8'h01, 0);
    send(8'h03, 0);
    send(8'hAA, 0);
    send(8'hBB, 0);
    send(8'hCC, 0);
`ifdef LOADER_CHECKSUM_EN
    iByteValid = 1'b0;
    @(negedge Clock);
    send(8'hDE, 0);
`endif
    iByteValid = 1'b0;
    repeat (3) @(negedge Clock);
    chk("t6_wcount",   wcount,                32'd1);
    chk("t6_a0",       {16'd0, wr_addr[0]},   32'd0);
    chk("t6_d0",       {4'd0, wr_data[0]},    32'h3AABBCC);
    chk("t6_done",     {31'd0, oDone},        32'd1);
    chk("t6_cpurst",   {31'd0, oCpuReset},    32'd0);

`ifdef LOADER_CHECKSUM_EN
    // Wrong checksum: word written, load rejected
    do_reset();
    send(8'h00, 0);
    send(8'h01, 0);
    send(8'h03, 0);
    send(8'hAA, 0);
    send(8'hBB, 0);
    send(8'hCC, 0);
    iByteValid = 1'b0;
    @(negedge Clock);
    send(8'h00, 0);
    iByteValid = 1'b0;
    repeat (3) @(negedge Clock);
    chk("t7_wcount",   wcount,                32'd1);
    chk("t7_error",    {31'd0, oError},       32'd1);
    chk("t7_done",     {31'd0, oDone},        32'd0);
    chk("t7_cpurst",   {31'd0, oCpuReset},    32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instruction_loader.md
# instruction_loader

Boot-time program loader that writes the instruction memory the MiniAlu core fetches from. It accepts a byte stream over a valid/ready handshake, parses a 16-bit word count, and assembles 28-bit instruction words from 4 bytes each. Each word is written to sequential instruction addresses, and the core is held in reset until the image is complete. It sits between the host byte source (UART receiver or bench) and the write port of the instruction RAM that replaces the fixed ROM.

## Interface
- MAX_WORDS, 256, largest accepted word count; larger headers are rejected.
- ADDR_WIDTH, 16, width of oWriteAddress; matches the core instruction pointer.
- Clock  in  1  single clock; all state changes on rising edge.
- Reset  in  1  asynchronous, active-high; forces the block to IDLE immediately.
- iByte  in  8  incoming stream byte.
- iByteValid  in  1  iByte is valid this cycle.
- oByteReady  out  1  block will accept iByte this cycle.
- oWriteEnable  out  1  one-cycle instruction RAM write strobe.
- oWriteAddress  out  ADDR_WIDTH  instruction RAM write address.
- oInstruction  out  28  instruction word; [27:24] opcode, [23:16] destination, [15:8] src1, [7:0] src0.
- oCpuReset  out  1  holds the MiniAlu in reset while high.
- oDone  out  1  image loaded; core released.
- oError  out  1  load rejected; core stays in reset.

## Operation
- A byte is accepted on a rising edge when iByteValid and oByteReady are both 1. Cycles with iByteValid low change nothing.
- Stream format, big-endian: LEN_HI, LEN_LO, then N words of 4 bytes (B0..B3).
- Word assembly: B0[3:0] → [27:24], B1 → [23:16], B2 → [15:8], B3 → [7:0].
- B0[7:4] must be 0. A nonzero value sends the block to ERROR, and that word is not written.
- States: IDLE (expects LEN_HI), LEN_LO, DATA, FLUSH, CHECK (macro only), DONE, ERROR.
- IDLE → LEN_LO on LEN_HI accept.
- LEN_LO → DATA on accept when 0 < N ≤ MAX_WORDS.
- LEN_LO → DONE when N = 0 (→ CHECK when the macro is enabled).
- LEN_LO → ERROR when N > MAX_WORDS.
- DATA: a 2-bit byte counter selects the field being loaded.
- On a B3 accept, the write is issued. The block stays in DATA if words remain, or goes to FLUSH after the last word.
- FLUSH lasts one cycle, then → DONE (→ CHECK when the macro is enabled).
- DONE and ERROR are terminal; only Reset leaves them.
- Write address starts at 0 and increments by 1 after every write. With N ≤ MAX_WORDS it never wraps.
- oByteReady is 1 in IDLE, LEN_LO, DATA and CHECK, and 0 in FLUSH, DONE and ERROR.
- oCpuReset = 1 in every state except DONE.
- oDone = 1 only in DONE; oError = 1 only in ERROR.
- Reset mid-load:
  - Partial words, the byte counter and the word count are discarded, and the address returns to 0.
  - RAM contents already written are not cleared.

## Timing
- Reset values: oByteReady 0 while Reset is high, then 1 (IDLE); oWriteEnable 0; oWriteAddress 0; oInstruction 0; oCpuReset 1; oDone 0; oError 0.
- Write, oWriteAddress and oInstruction are all registered:
  - If B3 is accepted at edge k, they are valid from edge k to edge k+1.
  - oWriteEnable is high for exactly that one cycle.
- Address increment takes effect at edge k+1.
- Back-to-back bytes at one per cycle are sustained in DATA; writes are never closer than 4 cycles apart.
- Without the macro, the final write is at cycle k..k+1, FLUSH ends at k+1, and DONE is entered with oCpuReset low from edge k+2. The core therefore never runs while a write is pending.
- ERROR on a bad header or bad B0 is entered at the edge that accepts the offending byte.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - One extra byte follows the last word (or LEN_LO when N = 0).
  - It must equal the XOR of all data bytes; the length bytes are excluded.
  - CHECK accepts that byte and goes → DONE on a match, → ERROR on a mismatch.
  - Words already written remain in RAM, but the core stays in reset.
- Undefined: no checksum byte; FLUSH goes straight to DONE, and LEN_LO with N = 0 goes straight to DONE.

## Test plan
- Stream 00 02 07 01 02 03 02 04 05 06, one per cycle → two write pulses (addr 0 = 0x7010203, addr 1 = 0x2040506), then oDone=1 and oCpuReset=0 two edges after the second B3.
- Same stream with iByteValid low for 3 cycles between every byte → identical writes and final state; no extra strobes.
- Header 00 00 → no writes, DONE after LEN_LO. Header 01 01 with MAX_WORDS=256 → ERROR, oByteReady=0, oCpuReset stays 1.
- Stream 00 01 17 … → ERROR at the B0 edge, oWriteEnable never asserted.
- Reset asserted mid-cycle after 00 02 07 01 → outputs return to reset values immediately. Reloading 00 01 03 AA BB CC then writes 0x3AABBCC at address 0.
- With LOADER_CHECKSUM_EN: 00 01 03 AA BB CC followed by checksum 0xDE → DONE. The same stream with checksum 0x00 → write occurs, then ERROR, oCpuReset stays 1.
